decimal_rx_parser: RTL and testbench
====================================

DECIMAL_RX_PARSER -- requirements
Module: decimal_rx_parser

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 10; maximum accepted decimal digit count.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  received ASCII byte.
REQ-005 SHALL have port new_rx_data  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-006 SHALL have port value  output  32  parsed magnitude; held until next value_valid.
REQ-007 SHALL have port isneg  output  1  sign of value: 1 = negative; held with value.
REQ-008 SHALL have port value_valid  output  1  one-cycle pulse; new value/isneg published.
REQ-009 SHALL have port parse_error  output  1  one-cycle pulse; malformed line discarded.
REQ-010 SHALL have port busy  output  1  high while a line is partially received.

Function
REQ-011 SHALL implement states IDLE, DIGITS, DRAIN; bytes are processed only on cycles with new_rx_data=1.
REQ-012 Terminator SHALL be "\n" (0x0A) or "\r" (0x0D); digit SHALL be "0"-"9" (0x30-0x39).
REQ-013 IDLE: "-" sets neg flag, go DIGITS; "+" clears neg flag, go DIGITS; digit loads acc=digit, count=1, go DIGITS; terminator ignored, stay IDLE; any other byte goes DRAIN.
REQ-014 DIGITS: digit computes acc*10+digit in 36-bit width, count+1; result > 0xFFFFFFFF or count already = MAX_DIGITS goes DRAIN.
REQ-015 DIGITS: terminator with count>=1 publishes value=acc[31:0], isneg=neg flag, pulses value_valid, goes IDLE.
REQ-016 DIGITS: terminator with count=0 (sign only) pulses parse_error, goes IDLE.
REQ-017 DIGITS: any other byte goes DRAIN.
REQ-018 DRAIN: non-terminator bytes are discarded; terminator pulses parse_error, goes IDLE.
REQ-019 value_valid and parse_error SHALL assert exactly one cycle after the terminator strobe, never both in the same cycle.
REQ-020 value and isneg SHALL change only in the cycle value_valid asserts.
REQ-021 "-0" SHALL publish value=0, isneg=1 unchanged; no normalisation.
REQ-022 acc, count and neg flag SHALL be cleared on every entry to IDLE.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 new_rx_data on back-to-back cycles SHALL be accepted at full rate, one byte per cycle.

Reset
REQ-025 rst SHALL force state IDLE, value=0, isneg=0, value_valid=0, parse_error=0, acc=0, count=0, neg flag=0.
REQ-026 rst mid-line SHALL discard the partial line with no value_valid or parse_error pulse; rst SHALL override a coincident new_rx_data.

Structure
REQ-027 Shared package SHALL hold ASCII constants (CHAR_LF, CHAR_CR, CHAR_MINUS, CHAR_PLUS, CHAR_0, CHAR_9) and the state encoding; the printing path SHALL reuse them.
REQ-028 One sub-module ascii_digit_decode (combinational: byte -> is_digit, 4-bit digit) SHALL be instantiated; all other logic stays inline.
REQ-029 Multiply-by-10 SHALL be implemented as (acc<<3)+(acc<<1) in 36 bits.

Verification
REQ-030 "-","1","2","3","\n" -> value_valid one cycle after "\n", value=123, isneg=1.
REQ-031 "4294967295\r" -> value=0xFFFFFFFF, isneg=0; "4294967296\n" -> parse_error, value unchanged.
REQ-032 "12a4\n" -> busy high from "1" until after "\n", parse_error once, no value_valid.
REQ-033 "+\n" -> parse_error; lone "\n" in IDLE -> no pulse, busy stays 0.
REQ-034 "99", rst for 1 cycle, "7\n" -> value=7, isneg=0, no pulse from the aborted line.
REQ-035 "00000000001\n" (11 digits) -> parse_error; "5\n" sent back-to-back with no idle cycles -> value=5.

Source files
------------

// File: rtl/decimal_rx_parser_pkg.sv
// Shared definitions for the decimal line parser.
// ASCII byte constants and the parser state encoding.
package decimal_rx_parser_pkg;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_PLUS  = 8'h2B;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/decimal_rx_parser_if.sv
// Byte-stream input and parsed-value output bundle.
// master drives bytes in, slave is the parser.
interface decimal_rx_parser_if;

    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [31:0] value;
    logic        isneg;
    logic        value_valid;
    logic        parse_error;
    logic        busy;

    modport master (
        output rx_data,
        output new_rx_data,
        input  value,
        input  isneg,
        input  value_valid,
        input  parse_error,
        input  busy
    );

    modport slave (
        input  rx_data,
        input  new_rx_data,
        output value,
        output isneg,
        output value_valid,
        output parse_error,
        output busy
    );

endinterface

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII decimal digit classifier.
// Non-digit bytes report digit = 0.
module ascii_digit_decode
    import decimal_rx_parser_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic [3:0] digit
);

    assign is_digit = (ch >= CHAR_0) && (ch <= CHAR_9);
    assign digit    = is_digit ? ch[3:0] : 4'd0;

endmodule

// File: rtl/decimal_rx_parser.sv
// Line-oriented signed decimal parser for a received byte stream.
// Publishes a 32-bit magnitude plus sign on each well-formed line.
module decimal_rx_parser
    import decimal_rx_parser_pkg::*;
#(
    parameter int MAX_DIGITS = 10
) (
    input  logic                clk,
    input  logic                rst,
    decimal_rx_parser_if.slave  bus
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    state_t        state;
    logic [31:0]   acc;
    logic [CW-1:0] count;
    logic          neg;

    logic          is_digit;
    logic [3:0]    digit;
    logic          is_term;
    logic [35:0]   acc36;
    logic [35:0]   prod;

    ascii_digit_decode u_dec (
        .ch       (bus.rx_data),
        .is_digit (is_digit),
        .digit    (digit)
    );

    assign is_term  = (bus.rx_data == CHAR_LF) ||
                      (bus.rx_data == CHAR_CR);
    assign acc36    = {4'd0, acc};
    assign prod     = (acc36 << 3) + (acc36 << 1) +
                      {32'd0, digit};
    assign bus.busy = (state != IDLE);

    // Parser FSM: one byte per strobe, pulses and result registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            acc             <= 32'd0;
            count           <= '0;
            neg             <= 1'b0;
            bus.value       <= 32'd0;
            bus.isneg       <= 1'b0;
            bus.value_valid <= 1'b0;
            bus.parse_error <= 1'b0;
        end else begin
            bus.value_valid <= 1'b0;
            bus.parse_error <= 1'b0;
            if (bus.new_rx_data) begin
                unique case (state)
                    IDLE: begin
                        if (bus.rx_data == CHAR_MINUS) begin
                            neg   <= 1'b1;
                            state <= DIGITS;
                        end else if (bus.rx_data == CHAR_PLUS) begin
                            neg   <= 1'b0;
                            state <= DIGITS;
                        end else if (is_digit) begin
                            acc   <= {28'd0, digit};
                            count <= CW'(1);
                            state <= DIGITS;
                        end else if (!is_term) begin
                            state <= DRAIN;
                        end
                    end
                    DIGITS: begin
                        if (is_digit) begin
                            if (count == CW'(MAX_DIGITS) ||
                                prod[35:32] != 4'd0) begin
                                state <= DRAIN;
                            end else begin
                                acc   <= prod[31:0];
                                count <= count + 1'b1;
                            end
                        end else if (is_term) begin
                            if (count != '0) begin
                                bus.value       <= acc;
                                bus.isneg       <= neg;
                                bus.value_valid <= 1'b1;
                            end else begin
                                bus.parse_error <= 1'b1;
                            end
                            acc   <= 32'd0;
                            count <= '0;
                            neg   <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (is_term) begin
                            bus.parse_error <= 1'b1;
                            acc             <= 32'd0;
                            count           <= '0;
                            neg             <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                    default: begin
                        acc   <= 32'd0;
                        count <= '0;
                        neg   <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decimal_rx_parser.sv
// Directed bench for decimal_rx_parser.
// Drives ASCII lines and checks published values and pulses.
module tb_decimal_rx_parser;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   vv_cnt;
    int   pe_cnt;
    int   both_cnt;
    int   vv0;
    int   pe0;
    logic post_vv;
    logic post_pe;

    decimal_rx_parser_if bus ();

    decimal_rx_parser #(.MAX_DIGITS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally output pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.value_valid) vv_cnt++;
        if (bus.parse_error) pe_cnt++;
        if (bus.value_valid && bus.parse_error) both_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bytes back-to-back, then sample pulses one cycle after the last.
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.rx_data     = s[i];
            bus.new_rx_data = 1'b1;
        end
        @(negedge clk);
        bus.new_rx_data = 1'b0;
        bus.rx_data     = 8'h00;
        #1;
        post_vv = bus.value_valid;
        post_pe = bus.parse_error;
    endtask

    task automatic idle_mark();
        @(negedge clk);
        #1;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        vv_cnt          = 0;
        pe_cnt          = 0;
        both_cnt        = 0;
        rst             = 1'b1;
        bus.rx_data     = 8'h00;
        bus.new_rx_data = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_value", bus.value, 32'd0);
        chk("rst_isneg", {31'd0, bus.isneg}, 32'd0);
        chk("rst_vv", {31'd0, bus.value_valid}, 32'd0);
        chk("rst_pe", {31'd0, bus.parse_error}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // negative value, pulse exactly one cycle after terminator
        vv0 = vv_cnt; pe0 = pe_cnt;
        send_str("-123\n");
        chk("neg_vv_timing", {31'd0, post_vv}, 32'd1);
        chk("neg_pe", {31'd0, post_pe}, 32'd0);
        chk("neg_value", bus.value, 32'd123);
        chk("neg_isneg", {31'd0, bus.isneg}, 32'd1);
        idle_mark();
        chk("neg_vv_once", vv_cnt - vv0, 32'd1);
        chk("neg_busy_after", {31'd0, bus.busy}, 32'd0);

        // largest representable magnitude, CR terminator
        send_str("4294967295\r");
        chk("max_vv", {31'd0, post_vv}, 32'd1);
        chk("max_value", bus.value, 32'hFFFF_FFFF);
        chk("max_isneg", {31'd0, bus.isneg}, 32'd0);

        // one past the maximum overflows
        send_str("4294967296\n");
        chk("ovf_pe", {31'd0, post_pe}, 32'd1);
        chk("ovf_vv", {31'd0, post_vv}, 32'd0);
        chk("ovf_value_held", bus.value, 32'hFFFF_FFFF);

        // bad character mid-line, busy held until terminator
        vv0 = vv_cnt; pe0 = pe_cnt;
        send_str("1");
        chk("bad_busy_1", {31'd0, bus.busy}, 32'd1);
        send_str("2a4");
        chk("bad_busy_2", {31'd0, bus.busy}, 32'd1);
        send_str("\n");
        chk("bad_pe", {31'd0, post_pe}, 32'd1);
        chk("bad_busy_end", {31'd0, bus.busy}, 32'd0);
        idle_mark();
        chk("bad_pe_once", pe_cnt - pe0, 32'd1);
        chk("bad_no_vv", vv_cnt - vv0, 32'd0);

        // sign only, then lone terminator in idle
        send_str("+\n");
        chk("sign_only_pe", {31'd0, post_pe}, 32'd1);
        vv0 = vv_cnt; pe0 = pe_cnt;
        send_str("\n");
        chk("lone_busy", {31'd0, bus.busy}, 32'd0);
        idle_mark();
        chk("lone_no_vv", vv_cnt - vv0, 32'd0);
        chk("lone_no_pe", pe_cnt - pe0, 32'd0);

        // reset mid-line, with a coincident byte strobe
        vv0 = vv_cnt; pe0 = pe_cnt;
        send_str("99");
        chk("abort_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        rst             = 1'b1;
        bus.rx_data     = 8'h35;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        rst             = 1'b0;
        bus.new_rx_data = 1'b0;
        #1;
        chk("abort_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_rst_value", bus.value, 32'd0);
        send_str("7\n");
        chk("abort_value", bus.value, 32'd7);
        chk("abort_isneg", {31'd0, bus.isneg}, 32'd0);
        idle_mark();
        chk("abort_vv_once", vv_cnt - vv0, 32'd1);
        chk("abort_no_pe", pe_cnt - pe0, 32'd0);

        // too many digits, then a good line at full rate
        vv0 = vv_cnt; pe0 = pe_cnt;
        send_str("00000000001\n5\n");
        chk("long_then_5_value", bus.value, 32'd5);
        idle_mark();
        chk("long_pe", pe_cnt - pe0, 32'd1);
        chk("long_vv", vv_cnt - vv0, 32'd1);

        // negative zero kept as-is
        send_str("-0\n");
        chk("negzero_vv", {31'd0, post_vv}, 32'd1);
        chk("negzero_value", bus.value, 32'd0);
        chk("negzero_isneg", {31'd0, bus.isneg}, 32'd1);

        idle_mark();
        chk("never_both", both_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
